// File: rtl/apb_ecc_cmd_slave.sv
// apb_ecc_cmd_slave: APB3 slave with shadow registers that queues ECC commands into a FIFO
// and hands them to the core over a valid/ready handshake, with a STATUS/RESULT readback and an irq.
module apb_ecc_cmd_slave #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int CMD_DEPTH       = 4,
  parameter bit WAIT_ON_FULL    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [AMBA_WORD-1:0]       CTRL,
  output logic [AMBA_WORD-1:0]       DATA_IN,
  output logic [AMBA_WORD-1:0]       CODEWORD_WIDTH,
  output logic [AMBA_WORD-1:0]       NOISE,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  input  logic                       result_valid,
  input  logic [AMBA_WORD-1:0]       result_data,
  output logic                       irq
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(CMD_DEPTH);

  logic [AMBA_WORD-1:0] r_data_in, r_cw, r_noise, r_result;
  logic                 r_done;
  logic [AMBA_WORD-1:0] r_mem_ctrl [CMD_DEPTH];
  logic [AMBA_WORD-1:0] r_mem_data [CMD_DEPTH];
  logic [AMBA_WORD-1:0] r_mem_cw   [CMD_DEPTH];
  logic [AMBA_WORD-1:0] r_mem_noise[CMD_DEPTH];
  logic [PW:0]          r_wr_ptr, r_rd_ptr, r_count;

  logic [2:0]           w_idx;
  logic                 w_access, w_addr_err, w_ctrl_wr, w_full, w_empty, w_pop, w_push;
  logic                 w_blocked, w_complete, w_rd_result, w_unused;
  logic [AMBA_WORD-1:0] w_status, w_rd_mux;

  assign w_unused   = ^PADDR[1:0];
  assign w_idx      = PADDR[4:2];
  assign w_access   = PSEL & PENABLE;
  // holes at 0x18/0x1C and writes to the read-only STATUS/RESULT are all bus errors
  assign w_addr_err = (|PADDR[AMBA_ADDR_WIDTH-1:5]) | (w_idx[2] & w_idx[1]) | (PWRITE & w_idx[2]);
  assign w_full     = r_count == DEPTH;
  assign w_empty    = r_count == '0;
  assign w_pop      = cmd_valid & cmd_ready;
  assign w_ctrl_wr  = PWRITE & (w_idx == 3'd0) & !w_addr_err;
  assign w_blocked  = w_access & w_ctrl_wr & w_full & !w_pop;
  assign PREADY     = !(WAIT_ON_FULL && w_blocked);
  assign PSLVERR    = w_access & (w_addr_err | (!WAIT_ON_FULL && w_blocked));
  assign w_complete = w_access & PREADY & !PSLVERR;
  assign w_push     = w_complete & w_ctrl_wr;
  assign w_rd_result = w_complete & !PWRITE & (w_idx == 3'd5);

  always_comb begin
    w_status = '0;
    w_status[0] = w_empty;
    w_status[1] = w_full;
    w_status[2] = r_done;
    w_status[8 +: PW+1] = r_count;
  end

  assign w_rd_mux = (w_idx == 3'd1) ? r_data_in :
                    (w_idx == 3'd2) ? r_cw :
                    (w_idx == 3'd3) ? r_noise :
                    (w_idx == 3'd4) ? w_status :
                    (w_idx == 3'd5) ? r_result : '0;
  assign PRDATA = (PSEL & !PWRITE & !w_addr_err) ? w_rd_mux : '0;

  assign cmd_valid      = !w_empty;
  assign CTRL           = r_mem_ctrl [r_rd_ptr[PW-1:0]];
  assign DATA_IN        = r_mem_data [r_rd_ptr[PW-1:0]];
  assign CODEWORD_WIDTH = r_mem_cw   [r_rd_ptr[PW-1:0]];
  assign NOISE          = r_mem_noise[r_rd_ptr[PW-1:0]];
  assign irq            = r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_in <= '0;
      r_cw      <= '0;
      r_noise   <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_complete & PWRITE & (w_idx == 3'd1)) r_data_in <= PWDATA;
      if (w_complete & PWRITE & (w_idx == 3'd2)) r_cw      <= PWDATA;
      if (w_complete & PWRITE & (w_idx == 3'd3)) r_noise   <= PWDATA;
      if (result_valid) r_result <= result_data;
      r_done <= result_valid | (r_done & !w_rd_result);
    end
  end

  // a push into a full FIFO only completes alongside a pop, so it reuses the slot being vacated
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        r_mem_ctrl[i]  <= '0;
        r_mem_data[i]  <= '0;
        r_mem_cw[i]    <= '0;
        r_mem_noise[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_ctrl [r_wr_ptr[PW-1:0]] <= PWDATA;
        r_mem_data [r_wr_ptr[PW-1:0]] <= r_data_in;
        r_mem_cw   [r_wr_ptr[PW-1:0]] <= r_cw;
        r_mem_noise[r_wr_ptr[PW-1:0]] <= r_noise;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
endmodule
